// File: rtl/i_memory.sv
// MEM stage of the pipeline: word-addressed data memory, MEM/WB register and branch select.
// Misaligned accesses are dropped, cancel write-back and latch a sticky error flag.
module i_memory #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_ctlin,
    input  logic [2:0]  m_ctlin,
    input  logic [31:0] add_result,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2,
    input  logic [4:0]  five_bit_muxin,
    output logic        pcsrc,
    output logic [31:0] branch_target,
    output logic [1:0]  wb_ctlout,
    output logic [31:0] read_data,
    output logic [31:0] alu_result_out,
    output logic [4:0]  write_reg,
    output logic        misalign_err
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0]          mem_q [DEPTH];
    logic [ADDR_BITS-1:0] word_idx;
    logic                 mem_read;
    logic                 mem_write;
    logic                 misaligned;
    logic                 mem_we;

    logic [1:0]  wb_ctl_d,     wb_ctl_q;
    logic [31:0] read_data_d,  read_data_q;
    logic [31:0] alu_res_d,    alu_res_q;
    logic [4:0]  write_reg_d,  write_reg_q;
    logic        misalign_d,   misalign_q;

    assign pcsrc         = m_ctlin[2] & zero;
    assign branch_target = add_result;

    // Upper address bits are ignored so the word index wraps modulo DEPTH.
    assign word_idx   = alu_result[ADDR_BITS+1:2];
    assign mem_read   = m_ctlin[1];
    assign mem_write  = m_ctlin[0];
    assign misaligned = (alu_result[1:0] != 2'b00) && (mem_read || mem_write);
    assign mem_we     = mem_write && !misaligned && !rst;

    always_comb begin
        wb_ctl_d    = misaligned ? 2'b00 : wb_ctlin;
        alu_res_d   = alu_result;
        write_reg_d = five_bit_muxin;
        misalign_d  = misalign_q | misaligned;
        read_data_d = 32'h0;
        if (mem_read && !misaligned) begin
            read_data_d = mem_q[word_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ctl_q    <= 2'b00;
            read_data_q <= 32'h0;
            alu_res_q   <= 32'h0;
            write_reg_q <= 5'd0;
            misalign_q  <= 1'b0;
        end else begin
            wb_ctl_q    <= wb_ctl_d;
            read_data_q <= read_data_d;
            alu_res_q   <= alu_res_d;
            write_reg_q <= write_reg_d;
            misalign_q  <= misalign_d;
        end
    end

    // Storage is deliberately not reset; a same-edge load sees the old word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[word_idx] <= rdata2;
        end
    end

    assign wb_ctlout      = wb_ctl_q;
    assign read_data      = read_data_q;
    assign alu_result_out = alu_res_q;
    assign write_reg      = write_reg_q;
    assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_i_memory.sv
// Scoreboard bench for i_memory: directed scenarios followed by random traffic
// checked against an array-based reference model.
module tb_i_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wb_ctlin;
    logic [2:0]  m_ctlin;
    logic [31:0] add_result;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2;
    logic [4:0]  five_bit_muxin;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic [1:0]  wb_ctlout;
    logic [31:0] read_data;
    logic [31:0] alu_result_out;
    logic [4:0]  write_reg;
    logic        misalign_err;

    i_memory #(.ADDR_BITS(8)) dut (
        .clk(clk), .rst(rst), .wb_ctlin(wb_ctlin), .m_ctlin(m_ctlin),
        .add_result(add_result), .zero(zero), .alu_result(alu_result),
        .rdata2(rdata2), .five_bit_muxin(five_bit_muxin), .pcsrc(pcsrc),
        .branch_target(branch_target), .wb_ctlout(wb_ctlout), .read_data(read_data),
        .alu_result_out(alu_result_out), .write_reg(write_reg), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] rd;
        logic        rd_known;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m   [256];
    bit          written [256];
    logic        err_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // One transaction: drive on the falling edge, predict the post-edge outputs.
    task automatic cyc(input logic r, input logic [1:0] wb, input logic [2:0] m,
                       input logic [31:0] add, input logic z, input logic [31:0] alu,
                       input logic [31:0] d2, input logic [4:0] wr);
        exp_t e;
        int   idx;
        logic mis;
        @(negedge clk);
        rst = r; wb_ctlin = wb; m_ctlin = m; add_result = add; zero = z;
        alu_result = alu; rdata2 = d2; five_bit_muxin = wr;
        idx = int'((alu / 4) % 256);
        mis = (alu % 4 != 0) && (m[1] || m[0]);
        if (r) begin
            e = '{wb: 2'b00, rd: 32'h0, rd_known: 1'b1, alu: 32'h0, wr: 5'd0, err: 1'b0};
            err_m = 1'b0;
        end else begin
            err_m = err_m | mis;
            e.wb  = mis ? 2'b00 : wb;
            e.alu = alu;
            e.wr  = wr;
            e.err = err_m;
            if (m[1] && !mis) begin
                e.rd = mem_m[idx];
                e.rd_known = written[idx];
            end else begin
                e.rd = 32'h0;
                e.rd_known = 1'b1;
            end
            if (m[0] && !mis) begin
                mem_m[idx]   = d2;
                written[idx] = 1'b1;
            end
        end
        sb_q.push_back(e);
        #1;
        chk("pcsrc", {31'h0, pcsrc}, {31'h0, m[2] & z});
        chk("branch_target", branch_target, add);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("wb_ctlout", {30'h0, wb_ctlout}, {30'h0, e.wb});
                if (e.rd_known) chk("read_data", read_data, e.rd);
                chk("alu_result_out", alu_result_out, e.alu);
                chk("write_reg", {27'h0, write_reg}, {27'h0, e.wr});
                chk("misalign_err", {31'h0, misalign_err}, {31'h0, e.err});
            end
        end
    end

    initial begin : stim
        logic [31:0] a;
        logic [2:0]  m;
        for (int i = 0; i < 256; i++) begin
            mem_m[i] = 32'h0;
            written[i] = 1'b0;
        end
        rst = 1'b1; wb_ctlin = 2'b00; m_ctlin = 3'b000; add_result = 32'h0;
        zero = 1'b0; alu_result = 32'h0; rdata2 = 32'h0; five_bit_muxin = 5'd0;

        cyc(1, 2'b11, 3'b000, 32'h0, 0, 32'h0, 32'h0, 5'd3);
        // store then load
        cyc(0, 2'b00, 3'b001, 32'h0, 0, 32'h10, 32'hDEADBEEF, 5'd1);
        cyc(0, 2'b11, 3'b010, 32'h0, 0, 32'h10, 32'h0, 5'd7);
        // branch select
        cyc(0, 2'b00, 3'b100, 32'h40, 1, 32'h0, 32'h0, 5'd0);
        cyc(0, 2'b00, 3'b100, 32'h40, 0, 32'h0, 32'h0, 5'd0);
        // simultaneous read/write returns old data
        cyc(0, 2'b00, 3'b001, 32'h0, 0, 32'h20, 32'h1, 5'd0);
        cyc(0, 2'b10, 3'b011, 32'h0, 0, 32'h20, 32'h2, 5'd2);
        cyc(0, 2'b10, 3'b010, 32'h0, 0, 32'h20, 32'h0, 5'd2);
        // misaligned store is dropped, flag sticks until reset
        cyc(0, 2'b10, 3'b001, 32'h0, 0, 32'h13, 32'h5, 5'd4);
        cyc(0, 2'b11, 3'b010, 32'h0, 0, 32'h10, 32'h0, 5'd4);
        cyc(0, 2'b11, 3'b000, 32'h0, 0, 32'h3, 32'h0, 5'd5);
        cyc(1, 2'b11, 3'b000, 32'h0, 0, 32'h0, 32'h0, 5'd0);
        cyc(0, 2'b11, 3'b000, 32'h0, 0, 32'h0, 32'h0, 5'd6);
        // reset wins over a store
        cyc(0, 2'b00, 3'b001, 32'h0, 0, 32'h30, 32'h12345678, 5'd0);
        cyc(1, 2'b11, 3'b001, 32'h9, 1, 32'h30, 32'hFFFF0000, 5'd9);
        cyc(0, 2'b01, 3'b010, 32'h0, 0, 32'h30, 32'h0, 5'd9);
        // address wrap
        cyc(0, 2'b00, 3'b001, 32'h0, 0, 32'h400, 32'hA, 5'd0);
        cyc(0, 2'b11, 3'b010, 32'h0, 0, 32'h0, 32'h0, 5'd1);
        // fill a small window so random loads are fully checked
        for (int i = 0; i < 16; i++)
            cyc(0, 2'b00, 3'b001, 32'h0, 0, 32'(i * 4), $urandom, 5'd0);

        for (int n = 0; n < 2000; n++) begin
            a = $urandom;
            a[9:2] = 8'($urandom_range(0, 15));
            a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            m = 3'($urandom);
            cyc(($urandom_range(0, 63) == 0), 2'($urandom), m, $urandom, 1'($urandom),
                a, $urandom, 5'($urandom));
        end

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
